// File: rtl/multicycle_core_ctrl_pkg.sv
// Shared types and constants for the multi-cycle core sequencer:
// FSM state encoding, fault-cause codes, NOP and default reset PC.
package multicycle_core_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF_REQ = 3'd0,
    S_IF_RSP = 3'd1,
    S_EX     = 3'd2,
    S_LS_REQ = 3'd3,
    S_LS_RSP = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } ctrl_state_t;

  localparam logic [1:0] FC_NONE   = 2'd0;
  localparam logic [1:0] FC_IF_ERR = 2'd1;
  localparam logic [1:0] FC_IF_TMO = 2'd2;
  localparam logic [1:0] FC_LS_TMO = 2'd3;

  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/multicycle_core_ctrl_timeout.sv
// Response-wait counter shared by the fetch and LSU wait states.
// Ports: clk, rst_n, clr_i, en_i (count), expired_o (count == TIMEOUT).
module resp_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expired_o = (cnt_q == W'(TIMEOUT));

  // Saturates at TIMEOUT so it never wraps back to a live count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_core_ctrl.sv
// Multi-cycle sequencer for the RV32 core: owns PC and IR, steps
// IF_REQ/IF_RSP/EX/LS_REQ/LS_RSP/WB over valid/ready memory handshakes.
// Ports: clk, rst (async, active-low); ifu_* fetch req/rsp; dec_* decoder
// hints; lsu_* data req/rsp; pc, inst; rf_we, csr_we, commit strobes;
// fault, fault_cause. MULTICYCLE_CORE_CTRL_PERF_EN adds perf_cycle and
// perf_instret (64-bit).
module multicycle_core_ctrl
  import multicycle_core_ctrl_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
  parameter int              TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  output logic [XLEN-1:0] ifu_req_addr,
  input  logic            ifu_rsp_valid,
  input  logic [31:0]     ifu_rsp_inst,
  input  logic            ifu_rsp_err,
  input  logic            dec_mem_rd,
  input  logic            dec_mem_wr,
  input  logic            dec_jump,
  input  logic [XLEN-1:0] dec_jump_pc,
  output logic            lsu_req_valid,
  input  logic            lsu_req_ready,
  input  logic            lsu_rsp_valid,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     inst,
  output logic            rf_we,
  output logic            csr_we,
  output logic            commit,
`ifdef MULTICYCLE_CORE_CTRL_PERF_EN
  output logic [63:0]     perf_cycle,
  output logic [63:0]     perf_instret,
`endif
  output logic            fault,
  output logic [1:0]      fault_cause
);

  ctrl_state_t     state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic            fault_q, fault_d;
  logic [1:0]      cause_q, cause_d;

  logic tmo_clr;
  logic tmo_en;
  logic tmo_exp;

  resp_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk       (clk),
    .rst_n     (rst),
    .clr_i     (tmo_clr),
    .en_i      (tmo_en),
    .expired_o (tmo_exp)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    fault_d       = fault_q;
    cause_d       = cause_q;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    rf_we         = 1'b0;
    csr_we        = 1'b0;
    commit        = 1'b0;
    tmo_clr       = 1'b0;
    tmo_en        = 1'b0;

    unique case (state_q)
      S_IF_REQ: begin
        ifu_req_valid = 1'b1;
        if (ifu_req_ready) begin
          state_d = S_IF_RSP;
          tmo_clr = 1'b1;
        end
      end

      // A response in the expiry cycle still wins.
      S_IF_RSP: begin
        if (ifu_rsp_valid) begin
          if (ifu_rsp_err) begin
            state_d = S_HALT;
            fault_d = 1'b1;
            cause_d = FC_IF_ERR;
          end else begin
            inst_d  = ifu_rsp_inst;
            state_d = S_EX;
          end
        end else if (tmo_exp) begin
          state_d = S_HALT;
          fault_d = 1'b1;
          cause_d = FC_IF_TMO;
        end else begin
          tmo_en = 1'b1;
        end
      end

      S_EX: begin
        if (dec_mem_rd || dec_mem_wr) begin
          state_d = S_LS_REQ;
        end else begin
          state_d = S_WB;
        end
      end

      S_LS_REQ: begin
        lsu_req_valid = 1'b1;
        if (lsu_req_ready) begin
          state_d = S_LS_RSP;
          tmo_clr = 1'b1;
        end
      end

      S_LS_RSP: begin
        if (lsu_rsp_valid) begin
          state_d = S_WB;
        end else if (tmo_exp) begin
          state_d = S_HALT;
          fault_d = 1'b1;
          cause_d = FC_LS_TMO;
        end else begin
          tmo_en = 1'b1;
        end
      end

      // Strobes are unconditional; decoder enables gate them outside.
      S_WB: begin
        rf_we   = 1'b1;
        csr_we  = 1'b1;
        commit  = 1'b1;
        pc_d    = dec_jump ? dec_jump_pc : pc_q + XLEN'(4);
        state_d = S_IF_REQ;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IF_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IF_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      fault_q <= 1'b0;
      cause_q <= FC_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
    end
  end

  assign ifu_req_addr = pc_q;
  assign pc           = pc_q;
  assign inst         = inst_q;
  assign fault        = fault_q;
  assign fault_cause  = cause_q;

`ifdef MULTICYCLE_CORE_CTRL_PERF_EN
  logic [63:0] pcyc_q;
  logic [63:0] pret_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcyc_q <= '0;
      pret_q <= '0;
    end else begin
      if (state_q != S_HALT) begin
        pcyc_q <= pcyc_q + 64'd1;
      end
      if (commit) begin
        pret_q <= pret_q + 64'd1;
      end
    end
  end

  assign perf_cycle   = pcyc_q;
  assign perf_instret = pret_q;
`endif

endmodule

// File: tb/tb_multicycle_core_ctrl.sv
// Self-checking bench for multicycle_core_ctrl: vector table of
// instructions plus directed wait, timeout, error and reset sequences.
module tb_multicycle_core_ctrl;

  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_rsp_inst;
  logic        dec_mem_rd, dec_mem_wr, dec_jump;
  logic [31:0] dec_jump_pc;
  logic        lsu_req_ready, lsu_rsp_valid;

  logic        ifu_req_valid, lsu_req_valid;
  logic [31:0] ifu_req_addr, pc, inst;
  logic        rf_we, csr_we, commit, fault;
  logic [1:0]  fault_cause;

  logic        t4_ifu_req_valid, t4_lsu_req_valid;
  logic [31:0] t4_ifu_req_addr, t4_pc, t4_inst;
  logic        t4_rf_we, t4_csr_we, t4_commit, t4_fault;
  logic [1:0]  t4_fault_cause;

`ifdef MULTICYCLE_CORE_CTRL_PERF_EN
  logic [63:0] perf_cycle, perf_instret;
  logic [63:0] t4_perf_cycle, t4_perf_instret;
`endif

  always #5 clk = ~clk;

  multicycle_core_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_req_addr  (ifu_req_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_inst  (ifu_rsp_inst),
    .ifu_rsp_err   (ifu_rsp_err),
    .dec_mem_rd    (dec_mem_rd),
    .dec_mem_wr    (dec_mem_wr),
    .dec_jump      (dec_jump),
    .dec_jump_pc   (dec_jump_pc),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_rsp_valid (lsu_rsp_valid),
    .pc            (pc),
    .inst          (inst),
    .rf_we         (rf_we),
    .csr_we        (csr_we),
    .commit        (commit),
`ifdef MULTICYCLE_CORE_CTRL_PERF_EN
    .perf_cycle    (perf_cycle),
    .perf_instret  (perf_instret),
`endif
    .fault         (fault),
    .fault_cause   (fault_cause)
  );

  multicycle_core_ctrl #(
    .TIMEOUT (4)
  ) dut4 (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (t4_ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_req_addr  (t4_ifu_req_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_inst  (ifu_rsp_inst),
    .ifu_rsp_err   (ifu_rsp_err),
    .dec_mem_rd    (dec_mem_rd),
    .dec_mem_wr    (dec_mem_wr),
    .dec_jump      (dec_jump),
    .dec_jump_pc   (dec_jump_pc),
    .lsu_req_valid (t4_lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_rsp_valid (lsu_rsp_valid),
    .pc            (t4_pc),
    .inst          (t4_inst),
    .rf_we         (t4_rf_we),
    .csr_we        (t4_csr_we),
    .commit        (t4_commit),
`ifdef MULTICYCLE_CORE_CTRL_PERF_EN
    .perf_cycle    (t4_perf_cycle),
    .perf_instret  (t4_perf_instret),
`endif
    .fault         (t4_fault),
    .fault_cause   (t4_fault_cause)
  );

  int nchk = 0;
  int nerr = 0;
  int ncommit = 0;
  int t4_ncommit = 0;

  always @(negedge clk) begin
    if (commit) ncommit++;
    if (t4_commit) t4_ncommit++;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        jump;
    logic [31:0] jpc;
    logic        rd;
    logic        wr;
    logic [31:0] ins;
    int          cyc;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tv[8];

  task automatic idle_inputs();
    ifu_req_ready = 1'b1;
    ifu_rsp_valid = 1'b1;
    ifu_rsp_err   = 1'b0;
    ifu_rsp_inst  = NOP;
    dec_mem_rd    = 1'b0;
    dec_mem_wr    = 1'b0;
    dec_jump      = 1'b0;
    dec_jump_pc   = '0;
    lsu_req_ready = 1'b1;
    lsu_rsp_valid = 1'b1;
  endtask

  // Leaves the DUTs in IF_REQ, just after a falling edge.
  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Runs one instruction from IF_REQ; returns in the next IF_REQ.
  task automatic run_instr(input vec_t v, input logic [31:0] spc,
                           input string tag);
    int  cyc;
    logic stray;
    dec_jump     = v.jump;
    dec_jump_pc  = v.jpc;
    dec_mem_rd   = v.rd;
    dec_mem_wr   = v.wr;
    ifu_rsp_inst = v.ins;
    chk({tag, "_req"}, {ifu_req_valid, ifu_req_addr}, {1'b1, spc});
    cyc   = 1;
    stray = 1'b0;
    while (!commit && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!commit && (rf_we || csr_we)) stray = 1'b1;
    end
    chk({tag, "_cyc"}, cyc, v.cyc);
    chk({tag, "_stray"}, stray, 0);
    chk({tag, "_we"}, {rf_we, csr_we}, 2'b11);
    chk({tag, "_inst"}, inst, v.ins);
    @(posedge clk);
    #1;
    chk({tag, "_pc"}, pc, v.exp_pc);
    dec_jump   = 1'b0;
    dec_mem_rd = 1'b0;
    dec_mem_wr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c0;
    int   vcnt;
    vec_t v;
    logic [31:0] spc;

    tv[0] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0010_0093, 4, 32'h8000_0004};
    tv[1] = '{1'b1, 32'h8000_0100, 1'b0, 1'b0, 32'h0000_006f, 4, 32'h8000_0100};
    tv[2] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_a103, 6, 32'h8000_0104};
    tv[3] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0011_2023, 6, 32'h8000_0108};
    tv[4] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_006f, 4, 32'hFFFF_FFFC};
    tv[5] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0020_0113, 4, 32'h0000_0000};
    tv[6] = '{1'b1, 32'h0000_0102, 1'b0, 1'b0, 32'h0000_0063, 4, 32'h0000_0102};
    tv[7] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0030_0193, 4, 32'h0000_0106};

    // Reset state.
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("rst_pc", pc, RPC);
    chk("rst_inst", inst, NOP);
    chk("rst_fault", {fault, fault_cause}, 3'b000);
    chk("rst_strobes", {rf_we, csr_we, commit, lsu_req_valid}, 4'b0);
    chk("rst_ifreq", {ifu_req_valid, ifu_req_addr}, {1'b1, RPC});
    @(negedge clk);
    rst = 1'b1;

    // Vector table.
    spc = RPC;
    for (int i = 0; i < 8; i++) begin
      run_instr(tv[i], spc, $sformatf("v%0d", i));
      spc = tv[i].exp_pc;
    end
    chk("tbl_fault", fault, 1'b0);

    // Delayed LSU handshakes on a load.
    do_reset();
    dec_mem_rd    = 1'b1;
    lsu_req_ready = 1'b0;
    lsu_rsp_valid = 1'b0;
    c0 = ncommit;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (lsu_req_valid) vcnt++;
      if (i == 3) lsu_req_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    lsu_req_ready = 1'b0;
    if (lsu_req_valid) vcnt++;
    chk("ls_req_hold", vcnt, 4);
    for (int j = 0; j < 6; j++) begin
      if (j == 5) lsu_rsp_valid = 1'b1;
      if (commit) vcnt++;
      @(posedge clk);
      #1;
    end
    chk("ls_early_commit", vcnt, 4);
    chk("ls_wb_commit", commit, 1'b1);
    lsu_rsp_valid = 1'b0;
    dec_mem_rd    = 1'b0;
    @(posedge clk);
    #1;
    chk("ls_one_commit", ncommit - c0, 1);
    chk("ls_no_fault", fault, 1'b0);
    chk("ls_pc", pc, 32'h8000_0004);

    // Fetch timeout with TIMEOUT=4.
    do_reset();
    ifu_rsp_valid = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("tmo_not_yet", t4_fault, 1'b0);
    @(posedge clk);
    #1;
    chk("tmo_fault", {t4_fault, t4_fault_cause}, 3'b110);
    chk("tmo_pc", t4_pc, RPC);
    ifu_rsp_valid = 1'b1;
    c0 = t4_ncommit;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("tmo_absorb", {t4_ifu_req_valid, t4_lsu_req_valid}, 2'b00);
    chk("tmo_sticky", {t4_fault, t4_fault_cause, t4_pc}, {3'b110, RPC});
    chk("tmo_no_commit", t4_ncommit - c0, 0);

    // Response arriving in the expiry cycle wins.
    do_reset();
    ifu_rsp_valid = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    ifu_rsp_valid = 1'b1;
    ifu_rsp_inst  = 32'h0050_0293;
    @(posedge clk);
    #1;
    chk("tmo_edge_nofault", t4_fault, 1'b0);
    @(posedge clk);
    #1;
    chk("tmo_edge_commit", {t4_commit, t4_inst}, {1'b1, 32'h0050_0293});

    // Fetch bus error.
    do_reset();
    ifu_rsp_err  = 1'b1;
    ifu_rsp_inst = 32'h0070_0393;
    c0 = ncommit;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("err_fault", {fault, fault_cause}, 3'b101);
    ifu_rsp_err = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("err_pc_inst", {pc, inst}, {RPC, NOP});
    chk("err_no_commit", ncommit - c0, 0);
    chk("err_no_req", ifu_req_valid, 1'b0);

    // Asynchronous reset while waiting in LS_RSP.
    do_reset();
    v = '{1'b1, 32'h1234_0000, 1'b0, 1'b0, 32'h0000_006f, 4, 32'h1234_0000};
    run_instr(v, RPC, "rs_pre");
    dec_mem_rd    = 1'b1;
    ifu_rsp_inst  = 32'h0000_a103;
    lsu_rsp_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("rs_in_lsrsp", {lsu_req_valid, ifu_req_valid, pc},
        {2'b00, 32'h1234_0000});
    #3;
    rst = 1'b0;
    #1;
    chk("rs_ifreq", {ifu_req_valid, ifu_req_addr, pc}, {1'b1, RPC, RPC});
    chk("rs_strobes", {rf_we, csr_we, commit, lsu_req_valid}, 4'b0);
    chk("rs_inst", inst, NOP);

`ifdef MULTICYCLE_CORE_CTRL_PERF_EN
    do_reset();
    spc = RPC;
    for (int i = 0; i < 10; i++) begin
      v = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0010_0093, 4, spc + 32'd4};
      run_instr(v, spc, $sformatf("pf%0d", i));
      spc = spc + 32'd4;
    end
    chk("perf_instret", perf_instret, 64'd10);
    chk("perf_cycle", perf_cycle, 64'd40);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
